alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked, sequential ALU; successor to the team's 3-bit combinational 4-function ALU. It registers operands on a valid/ready input handshake and computes one of eight operations at width W. The result and status flags are held on a valid/ready output port until they are consumed. It sits between an operand source (sequencer or register file) and a result sink, and multiplication runs as a multi-cycle shift-add.

## Interface
- W, default 8: operand width; must be ≥ 2 and a power of 2.
- SHW, default $clog2(W): shift-amount width, derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op offer.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  operation select.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  sink accepts result.
- res  out  2W  result, zero-extended unless stated.
- carry  out  1  carry/borrow flag.
- ovf  out  1  signed (two's-complement) overflow flag.
- zero  out  1  res == 0.

## Operation
- Op codes:
  - 0 ADD: res[W:0] = a + b; carry = res[W].
  - 1 SUB: res[W-1:0] = a − b mod 2^W; carry = borrow (a < b unsigned).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: res[W-1:0] = a << b[SHW-1:0], truncated to W.
  - 6 SHR: logical, res[W-1:0] = a >> b[SHW-1:0].
  - 7 MUL: unsigned, res = full 2W-bit product.
- ovf:
  - ADD: set when a[W-1] == b[W-1] != sum[W-1].
  - SUB: set when a[W-1] != b[W-1] and diff[W-1] != a[W-1].
  - Otherwise 0.
- carry is 0 for ops 2–7.
- Unused upper res bits are 0.
- The state machine has three states:
  - IDLE: in_ready = 1. An input handshake (in_valid & in_ready) captures op, a and b.
    - Op 0–6: result computed that edge → DONE.
    - Op 7: → BUSY, iteration counter = 0.
  - BUSY: one shift-add step per cycle (LSB-first on b). After W steps → DONE with the product registered.
  - DONE: out_valid = 1. res and flags are held stable. out_ready → IDLE.
- No new operand is accepted outside IDLE; in_valid is ignored there.
- in_valid and in_ready are combinationally independent of each other, and in_ready is not a function of out_ready.
- Reset: synchronous, any state → IDLE.
  - After reset: in_ready = 1, out_valid = 0, res = 0, carry = 0, ovf = 0, zero = 0.
  - An in-flight MUL is discarded with no output.
- rst has priority over every handshake in the same cycle.

## Timing
- Ops 0–6: handshake at edge k → out_valid high from edge k (visible cycle k+1). Latency 1.
- Op 7: handshake at edge k → BUSY for W cycles → out_valid from edge k+W+1. For W=8 this is latency 9.
- Output handshake at edge m (out_valid & out_ready) → IDLE at m, so in_ready is visible in cycle m+1.
- Maximum throughput:
  - Ops 0–6: one operation per 2 cycles.
  - MUL: one per W+2 cycles.
- out_ready held high in DONE is consumed on the first DONE cycle. out_ready asserted outside DONE has no effect.
- Backpressure: res and flags must not change while out_valid = 1 and out_ready = 0.

## Structure
- Package alu_pkg holds:
  - Op-code localparams: OP_ADD … OP_MUL.
  - State encoding: S_IDLE, S_BUSY, S_DONE.
- Sub-module alu_mul_seq (parameter W):
  - Ports: clk, rst, start, a, b → done, prod[2W-1:0].
  - Contains the shift-add datapath and a SHW+1-bit counter.
- The top level holds the FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
All scenarios use W=8.
- Reset mid-MUL: assert rst during BUSY cycle 3 → next cycle in_ready = 1, out_valid = 0, res = 0; no stale result appears afterward.
- ADD a=200, b=100, out_ready=1 → out_valid one cycle after the handshake, res=300 (0x012C), carry=1, ovf=0, zero=0. Then IDLE again.
- SUB:
  - a=5, b=7 → res=0x00FE, carry=1, ovf=0.
  - a=0x80, b=0x01 → res=0x007F, carry=0, ovf=1.
- Logic, shift and zero:
  - XOR a=0x5A, b=0x5A → res=0, zero=1.
  - SHL a=0x81, b=0x0B (shift 3) → res=0x0008.
  - SHR a=0x80, b=7 → res=0x0001.
- MUL a=255, b=255 → in_ready low for 9 cycles, out_valid at handshake+9, res=65025 (0xFE01), carry=ovf=0.
- Backpressure: out_ready=0 for 5 cycles after ADD 1+1 → res=2 held stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE next cycle and the next operand is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the sequential ALU.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_AND = 3'd2;
  localparam op_t OP_OR  = 3'd3;
  localparam op_t OP_XOR = 3'd4;
  localparam op_t OP_SHL = 3'd5;
  localparam op_t OP_SHR = 3'd6;
  localparam op_t OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input op_t op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand offer and result return channels of the sequential ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  op_t            op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] res;
  logic           carry;
  logic           ovf;
  logic           zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, carry, ovf, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, carry, ovf, zero
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: loads on start, one LSB-first step per cycle,
// pulses done for one cycle once all W multiplier bits are consumed.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int SHW = $clog2(W);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(W-1);

  logic [2*W-1:0] mcand_reg;
  logic [2*W-1:0] acc_reg;
  logic [W-1:0]   mplier_reg;
  logic [SHW:0]   cnt_reg;
  logic           run_reg;
  logic           done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        mcand_reg  <= {{W{1'b0}}, a};
        mplier_reg <= b;
        acc_reg    <= '0;
        cnt_reg    <= '0;
        run_reg    <= 1'b1;
      end else if (run_reg) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
        // Last step lands in acc_reg on the same edge that raises done.
        if (cnt_reg == CNT_LAST) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign prod = acc_reg;
endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU: single-cycle ops finish on the accept edge, MUL runs
// through alu_mul_seq; results are held until the sink takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst,
  alu_seq_if.slave    bus
);
  localparam int SHW = $clog2(W);

  state_t         state_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;
  logic [2*W-1:0] res_reg;
  logic           carry_reg;
  logic           ovf_reg;
  logic           zero_reg;

  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [SHW-1:0] shamt;
  logic [2*W-1:0] alu_res;
  logic           alu_carry;
  logic           alu_ovf;

  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;

  always_comb begin
    sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w    = {1'b0, bus.a} - {1'b0, bus.b};
    shamt     = bus.b[SHW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res   = {{(W-1){1'b0}}, sum_w};
        alu_carry = sum_w[W];
        alu_ovf   = (bus.a[W-1] == bus.b[W-1]) && (sum_w[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        // diff_w[W] is the borrow out, i.e. a < b unsigned.
        alu_res   = {{W{1'b0}}, diff_w[W-1:0]};
        alu_carry = diff_w[W];
        alu_ovf   = (bus.a[W-1] != bus.b[W-1]) && (diff_w[W-1] != bus.a[W-1]);
      end
      OP_AND:  alu_res = {{W{1'b0}}, bus.a & bus.b};
      OP_OR:   alu_res = {{W{1'b0}}, bus.a | bus.b};
      OP_XOR:  alu_res = {{W{1'b0}}, bus.a ^ bus.b};
      OP_SHL:  alu_res = {{W{1'b0}}, bus.a << shamt};
      OP_SHR:  alu_res = {{W{1'b0}}, bus.a >> shamt};
      default: alu_res = '0;
    endcase
  end

  assign mul_start = (state_reg == S_IDLE) && bus.in_valid && is_mul(bus.op);

  alu_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_reg <= 1'b0;
            if (is_mul(bus.op)) begin
              state_reg <= S_BUSY;
            end else begin
              state_reg     <= S_DONE;
              out_valid_reg <= 1'b1;
              res_reg       <= alu_res;
              carry_reg     <= alu_carry;
              ovf_reg       <= alu_ovf;
              zero_reg      <= (alu_res == '0);
            end
          end
        end
        S_BUSY: begin
          if (mul_done) begin
            state_reg     <= S_DONE;
            out_valid_reg <= 1'b1;
            res_reg       <= mul_prod;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= (mul_prod == '0);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.res       = res_reg;
  assign bus.carry     = carry_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq at W=8 with an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;
  logic [63:0] obs_res;

  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic and signed range checks.
  function automatic void model(input int o, input int x, input int y,
                                output logic [63:0] r, output logic c, output logic v);
    int full;
    int half;
    int sx;
    int sy;
    int t;
    full = 1 << W;
    half = 1 << (W - 1);
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    c = 1'b0;
    v = 1'b0;
    case (o)
      0: begin
        r = 64'(x + y);
        c = (x + y) >= full;
        t = sx + sy;
        v = (t >= half) || (t < -half);
      end
      1: begin
        r = (x >= y) ? 64'(x - y) : 64'(x - y + full);
        c = x < y;
        t = sx - sy;
        v = (t >= half) || (t < -half);
      end
      2: r = 64'(x & y);
      3: r = 64'(x | y);
      4: r = 64'(x ^ y);
      5: r = 64'((x << (y % W)) % full);
      6: r = 64'(x >> (y % W));
      default: r = 64'(x * y);
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic transact(input string tag, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    int waits;
    logic busy_ok;
    logic [63:0] er;
    logic ec;
    logic ev;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    issue(o, x, y);
    waits = 0;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && waits < 40) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      waits++;
    end
    chk({tag, "_wait"}, 64'(waits), (o == 3'd7) ? 64'(W + 1) : 64'd0);
    chk({tag, "_busy_in_ready_low"}, 64'(busy_ok), 64'd1);
    model(int'(o), int'(x), int'(y), er, ec, ev);
    chk({tag, "_res"}, 64'(bus.res), er);
    chk({tag, "_carry"}, 64'(bus.carry), 64'(ec));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ev));
    chk({tag, "_zero"}, 64'(bus.zero), 64'(er == 64'd0));
    obs_res = 64'(bus.res);
    $display("op=%0d a=0x%02h b=0x%02h res=0x%04h c=%0b v=%0b z=%0b wait=%0d",
             o, x, y, bus.res, bus.carry, bus.ovf, bus.zero, waits);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int vcount;
    int d;
    logic [2:0] ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_res", 64'(bus.res), 64'd0);
    chk("reset_flags", {61'd0, bus.carry, bus.ovf, bus.zero}, 64'd0);

    bus.out_ready = 1'b1;
    transact("add", OP_ADD, 8'd200, 8'd100);
    chk("add_res_const", obs_res, 64'h012C);
    consume("add");

    transact("sub_borrow", OP_SUB, 8'd5, 8'd7);
    chk("sub_borrow_const", obs_res, 64'h00FE);
    consume("sub_borrow");
    transact("sub_ovf", OP_SUB, 8'h80, 8'h01);
    chk("sub_ovf_const", obs_res, 64'h007F);
    consume("sub_ovf");

    transact("xor_zero", OP_XOR, 8'h5A, 8'h5A);
    consume("xor_zero");
    transact("shl", OP_SHL, 8'h81, 8'h0B);
    chk("shl_const", obs_res, 64'h0008);
    consume("shl");
    transact("shr", OP_SHR, 8'h80, 8'h07);
    chk("shr_const", obs_res, 64'h0001);
    consume("shr");

    transact("mul_max", OP_MUL, 8'd255, 8'd255);
    chk("mul_max_const", obs_res, 64'hFE01);
    consume("mul_max");

    // Reset during the third BUSY cycle must drop the product entirely.
    bus.out_ready = 1'b0;
    chk("rmul_in_ready", 64'(bus.in_ready), 64'd1);
    issue(OP_MUL, 8'h37, 8'h59);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmul_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("rmul_out_valid_after", 64'(bus.out_valid), 64'd0);
    chk("rmul_res_after", 64'(bus.res), 64'd0);
    chk("rmul_flags_after", {61'd0, bus.carry, bus.ovf, bus.zero}, 64'd0);
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    chk("rmul_no_stale_valid", 64'(vcount), 64'd0);

    // Backpressure: result held, new offer ignored until the sink takes it.
    bus.out_ready = 1'b0;
    transact("bp_add", OP_ADD, 8'd1, 8'd1);
    bus.op = OP_SUB;
    bus.a = 8'd9;
    bus.b = 8'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res_held", 64'(bus.res), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    transact("bp_next", OP_MUL, 8'd3, 8'd3);
    chk("bp_next_const", obs_res, 64'd9);
    consume("bp_next");

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      bus.out_ready = 1'($urandom);
      transact("rnd", ro, ra, rb);
      if (bus.out_ready == 1'b0) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("rnd_hold", 64'(bus.res), obs_res);
        end
      end
      consume("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
